// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial unsigned subtractor driving one full-subtractor cell LSB-first.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             brw_q, brw_d, d_bit, borrow_q, zero_q;
  assign d_bit = a_q[0] ^ b_q[0] ^ brw_q;
  assign brw_d = (~a_q[0] & b_q[0]) | (~a_q[0] & brw_q) | (b_q[0] & brw_q);
  assign res_d = {d_bit, res_q[WIDTH-1:1]};
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
  // Result outputs are captured once on entry to DONE so they never ripple during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          brw_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          res_q <= res_d;
          brw_q <= brw_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q  <= DONE;
            diff_q   <= res_d;
            borrow_q <= brw_d;
            zero_q   <= ~|res_d;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed checks on WIDTH=8 and WIDTH=32 instances.
module tb_serial_sub_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic iv8 = 1'b0, or8 = 1'b1, ir8, ov8, br8, z8;
  logic [7:0] a8 = '0, b8 = '0, d8;
  logic iv32 = 1'b0, or32 = 1'b1, ir32, ov32, br32, z32;
  logic [31:0] a32 = '0, b32 = '0, d32;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  serial_sub_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .borrow(br8), .zero(z8)
  );
  serial_sub_ctrl #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .out_valid(ov32), .out_ready(or32), .diff(d32), .borrow(br32), .zero(z32)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic start8(input logic [7:0] av, input logic [7:0] bv);
    int n = 0;
    while (!ir8 && n < 50) begin @(posedge clk); #1; n++; end
    chk("ready8", ir8, 1);
    a8 = av; b8 = bv; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask
  task automatic wait8(input string tag);
    int n = 0;
    while (!ov8 && n < 100) begin @(posedge clk); #1; n++; end
    chk({tag, "_lat"}, n, 8);
  endtask
  task automatic res8(input string tag, input logic [7:0] d, input logic br, input logic z);
    chk({tag, "_diff"}, d8, d);
    chk({tag, "_borrow"}, br8, br);
    chk({tag, "_zero"}, z8, z);
    chk({tag, "_busy"}, ir8, 0);
  endtask
  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] d, input logic br, input logic z);
    start8(av, bv);
    wait8(tag);
    res8(tag, d, br, z);
    @(posedge clk); #1;
    chk({tag, "_ir_back"}, ir8, 1);
    chk({tag, "_ov_drop"}, ov8, 0);
  endtask
  initial begin
    #1;
    chk("rst_ov", ov8, 0);
    chk("rst_ir", ir8, 1);
    chk("rst_diff", d8, 0);
    chk("rst_borrow", br8, 0);
    chk("rst_zero", z8, 0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    op8("basic", 8'h5A, 8'h3C, 8'h1E, 0, 0);
    op8("under", 8'h00, 8'h01, 8'hFF, 1, 0);
    op8("msb", 8'h80, 8'h7F, 8'h01, 0, 0);
    op8("equal", 8'hA5, 8'hA5, 8'h00, 0, 1);
    op8("ff", 8'hFF, 8'h00, 8'hFF, 0, 0);
    op8("zmax", 8'h00, 8'hFF, 8'h01, 1, 0);
    or8 = 1'b0;
    start8(8'h10, 8'h20);
    wait8("bp");
    a8 = 8'h55; b8 = 8'h11; iv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      res8("bp_hold", 8'hF0, 1, 0);
      chk("bp_ov", ov8, 1);
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_ir_back", ir8, 1);
    chk("bp_ov_drop", ov8, 0);
    start8(8'h55, 8'h11);
    wait8("bp2");
    res8("bp2", 8'h44, 0, 0);
    @(posedge clk); #1;
    start8(8'h5A, 8'h3C);
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    chk("mid_ov", ov8, 0);
    chk("mid_diff", d8, 0);
    chk("mid_borrow", br8, 0);
    chk("mid_zero", z8, 0);
    chk("mid_ir", ir8, 1);
    #3 rst_n = 1'b1;
    #1 chk("mid_ir_rel", ir8, 1);
    op8("post", 8'h33, 8'h11, 8'h22, 0, 0);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] av, bv, ed;
      int n;
      av = $urandom;
      bv = (i == 0) ? av : (i == 1) ? 32'hFFFF_FFFF : $urandom;
      if (i == 1) av = '0;
      ed = av - bv;
      n = 0;
      while (!ir32 && n < 50) begin @(posedge clk); #1; n++; end
      chk("w32_ready", ir32, 1);
      a32 = av; b32 = bv; iv32 = 1'b1;
      @(posedge clk); #1;
      iv32 = 1'b0;
      n = 0;
      while (!ov32 && n < 100) begin @(posedge clk); #1; n++; end
      chk("w32_lat", n, 32);
      chk("w32_diff", d32, ed);
      chk("w32_borrow", br32, av < bv);
      chk("w32_zero", z32, av == bv);
      @(posedge clk); #1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Sequencing controller for a single one-bit full-subtractor cell, producing unsigned WIDTH-bit subtraction results.
- Accepts an operand pair (a, b) over a valid/ready handshake.
- Feeds the cell LSB-first, one bit per clock, with a registered borrow chain.
- Presents diff, borrow and zero on a valid/ready output handshake.
- Intended as the area-minimal subtract unit in the arithmetic datapath, in place of a WIDTH-bit parallel subtractor.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  controller can accept an operand pair.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- out_valid  output  1  diff/borrow/zero hold a completed result.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  (a - b) mod 2^WIDTH.
- borrow  output  1  final borrow out; 1 iff a < b (unsigned).
- zero  output  1  1 iff a == b.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset (rst_n low, at any time and without waiting for clk):
  - FSM goes to IDLE.
  - Operand shift registers, result register, borrow flop and bit counter clear to 0.
  - Outputs: in_ready=1 (as soon as rst_n is released), out_valid=0, diff=0, borrow=0, zero=0.
- Bit cell (x = minuend bit, y = subtrahend bit, z = borrow in):
  - D = x^y^z.
  - B = (~x&y)|(~x&z)|(y&z).
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready:
    - capture a and b into shift registers;
    - clear borrow flop and counter;
    - go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - apply cell to a_sr[0], b_sr[0], borrow flop;
    - shift D into result register from the MSB side (result shifts right);
    - load B into borrow flop;
    - shift a_sr and b_sr right by one;
    - increment counter.
    - On the cycle where counter==WIDTH-1, go to DONE.
  - DONE: in_ready=0, out_valid=1.
    - diff = result register; borrow = borrow flop; zero = (diff==0).
    - On out_valid&&out_ready, go to IDLE.
- Latency:
  - Operands accepted at clk edge T.
  - out_valid rises after edge T+WIDTH, so the result is visible in the cycle following that edge.
  - Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH run cycles, handshake out). No same-cycle accept on result retirement.
- Output stability: diff, borrow and zero change only on entry to DONE or on reset. They hold their last values in IDLE and RUN, but are qualified only by out_valid.
- Backpressure: DONE holds indefinitely while out_ready=0, with all outputs stable.
- Input changes: changes on a/b/in_valid while in RUN or DONE are ignored (in_ready=0).
- Stray signals: out_ready asserted outside DONE has no effect.
- Boundary cases:
  - a=0, b=2^WIDTH-1 → diff=1, borrow=1.
  - a=b → diff=0, borrow=0, zero=1.
  - Borrow from the MSB is reported, never wrapped into diff.
- Reset mid-RUN or mid-DONE aborts the operation; the partial result is discarded and never flagged valid.
- Counter width: clog2(WIDTH) bits, and must not wrap before the RUN→DONE transition for WIDTH=32.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, out_ready=1 → exactly 8 cycles after accept: out_valid=1, diff=0x1E, borrow=0, zero=0. in_ready returns to 1 the cycle after the out handshake.
- a=0x00, b=0x01 → diff=0xFF, borrow=1, zero=0. Then a=0x80, b=0x7F → diff=0x01, borrow=0.
- a=b=0xA5 → diff=0x00, borrow=0, zero=1. Then a=0xFF, b=0x00 → diff=0xFF, borrow=0, zero=0.
- Backpressure:
  - Stimulus: a=0x10, b=0x20, out_ready held 0 for 5 cycles in DONE, with in_valid=1 and different a/b driven meanwhile.
  - Expected: diff=0xF0, borrow=1 held stable and in_ready=0 throughout.
  - Expected: the second pair is accepted only after out_ready=1 and in_ready is reasserted.
- Reset mid-operation:
  - Stimulus: rst_n driven low asynchronously (between edges) 3 cycles into RUN.
  - Expected: out_valid, diff, borrow and zero go to 0 and in_ready goes to 1 immediately (in_ready as soon as rst_n is released).
  - Expected: a following op a=0x33, b=0x11 yields diff=0x22 after 8 cycles.
- WIDTH=32 instance: 16 back-to-back random pairs with out_ready=1 → each result matches (a-b) mod 2^32 and a<b. Accept-to-valid latency is 32 on every operation.
